// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter for two requesters feeding a shared word FIFO
// that schedules one word at a time into a 4-byte UART transmitter.
module uart_tx_sched #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req0_valid_i,
  input  logic [31:0]              req0_data_i,
  output logic                     req0_ready_o,
  input  logic                     req1_valid_i,
  input  logic [31:0]              req1_data_i,
  output logic                     req1_ready_o,
  output logic [31:0]              tx_sdata_o,
  output logic                     tx_start_o,
  input  logic                     tx_done_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     idle_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_e;
  state_e        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   tx_sdata_q;
  logic          prio_q, first_q, tx_start_q, full, push, pop;
  // fullness uses the registered count only, so a same-cycle pop never frees a slot
  assign full         = count_q == (AW+1)'(DEPTH);
  assign req0_ready_o = rstn && !full && req0_valid_i && !(req1_valid_i && prio_q);
  assign req1_ready_o = rstn && !full && req1_valid_i && !(req0_valid_i && !prio_q);
  assign push         = req0_ready_o || req1_ready_o;
  assign pop          = state_q == IDLE && count_q != '0;
  assign count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
  assign tx_sdata_o   = tx_sdata_q;
  assign tx_start_o   = tx_start_q;
  assign fifo_count_o = count_q;
  assign idle_o       = state_q == IDLE && count_q == '0;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      prio_q     <= 1'b0;
      first_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_sdata_q <= '0;
    end else begin
      count_q    <= count_d;
      tx_start_q <= pop;
      first_q    <= state_q == START;
      if (push) begin
        mem_q[tail_q] <= req0_ready_o ? req0_data_i : req1_data_i;
        tail_q        <= tail_q + AW'(1);
        prio_q        <= req0_ready_o;
      end
      // the head leaves the FIFO on the edge entering START so data and pulse align
      if (pop) begin
        tx_sdata_q <= mem_q[head_q];
        head_q     <= head_q + AW'(1);
      end
      case (state_q)
        IDLE:      if (pop) state_q <= START;
        START:     state_q <= WAIT_DONE;
        WAIT_DONE: if (!first_q && tx_done_i) state_q <= GAP;
        default:   state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized and directed stimulus with a queue scoreboard for uart_tx_sched.
module tb_uart_tx_sched;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, tx_done = 1'b0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        r0, r1, tx_start_o, idle_o;
  logic [31:0] tx_sdata_o;
  logic [$clog2(DEPTH):0] fifo_count_o;
  int          checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [31:0] sent[$];
  logic        mprio = 1'b0, e0, e1, acc0 = 1'b0, acc1 = 1'b0;
  bit          hold_low = 0, stuck = 0, busy = 0;
  int          cnt = 0;

  uart_tx_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid_i(v0), .req0_data_i(d0), .req0_ready_o(r0),
    .req1_valid_i(v1), .req1_data_i(d1), .req1_ready_o(r1),
    .tx_sdata_o(tx_sdata_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done),
    .fifo_count_o(fifo_count_o), .idle_o(idle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: a queue of accepted words plus the round-robin pointer.
  always @(negedge clk) begin
    e0 = 1'b0;
    e1 = 1'b0;
    if (rstn && q.size() < DEPTH) begin
      if (v0 && v1) begin
        e0 = !mprio;
        e1 = mprio;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk("req0_ready", 32'(r0), 32'(e0));
    chk("req1_ready", 32'(r1), 32'(e1));
    if (rstn) chk("fifo_count", 32'(fifo_count_o), 32'(q.size()));
    if (!rstn) begin
      q.delete();
      mprio = 1'b0;
    end else if (e0) begin
      q.push_back(d0);
      mprio = 1'b1;
    end else if (e1) begin
      q.push_back(d1);
      mprio = 1'b0;
    end
    acc0 = e0;
    acc1 = e1;
  end

  // Monitor: every start pulse must carry the oldest accepted word.
  always @(posedge clk) begin
    #1;
    if (tx_start_o === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_start: unexpected pulse with data %h, expected no pulse", tx_sdata_o);
      end else begin
        chk("tx_sdata", tx_sdata_o, q.pop_front());
        sent.push_back(tx_sdata_o);
      end
    end
  end

  // Transmitter model: random word time, optional stall or stuck-high done.
  initial forever begin
    @(posedge clk);
    #3;
    if (!rstn) begin
      busy = 0;
      tx_done = stuck;
    end else if (tx_start_o) begin
      busy = 1;
      cnt = $urandom_range(1, 4);
      tx_done = stuck;
    end else if (stuck) tx_done = 1'b1;
    else if (tx_done) begin
      tx_done = 1'b0;
      busy = 0;
    end else if (busy && !hold_low) begin
      if (cnt == 0) tx_done = 1'b1;
      else cnt--;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      step();
      if (idle_o === 1'b1 && q.size() == 0) break;
    end
    checks++;
    if (i == lim) begin
      errors++;
      $display("FAIL %s: idle not reached within %0d cycles, got idle=%b, expected 1", name, lim, idle_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a[2], b[2], w[4];
    int i0, i1, k;
    // reset state, with both valids high to show readies stay low
    rstn = 1'b0;
    v0 = 1'b1;
    v1 = 1'b1;
    d0 = 32'h1;
    d1 = 32'h2;
    repeat (3) step();
    chk("reset tx_sdata", tx_sdata_o, 32'h0);
    chk("reset tx_start", 32'(tx_start_o), 32'h0);
    chk("reset idle", 32'(idle_o), 32'h1);
    chk("reset fifo_count", 32'(fifo_count_o), 32'h0);
    v0 = 1'b0;
    v1 = 1'b0;
    rstn = 1'b1;
    // single word
    step();
    v0 = 1'b1;
    d0 = 32'hDEADBEEF;
    step();
    v0 = 1'b0;
    @(posedge clk);
    #1;
    chk("single tx_start", 32'(tx_start_o), 32'h1);
    chk("single tx_sdata", tx_sdata_o, 32'hDEADBEEF);
    for (k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (tx_done) break;
    end
    chk("single done seen", 32'(k < 20), 32'h1);
    chk("single idle in gap", 32'(idle_o), 32'h0);
    @(posedge clk);
    #1;
    chk("single idle after gap", 32'(idle_o), 32'h1);
    // contention
    do_reset();
    sent.delete();
    a[0] = 32'hA0A0_0000; a[1] = 32'hA1A1_1111;
    b[0] = 32'hB0B0_0000; b[1] = 32'hB1B1_1111;
    i0 = 0;
    i1 = 0;
    v0 = 1'b1; d0 = a[0];
    v1 = 1'b1; d1 = b[0];
    for (k = 0; k < 50 && (i0 < 2 || i1 < 2); k++) begin
      step();
      if (acc0) i0++;
      if (acc1) i1++;
      v0 = i0 < 2;
      v1 = i1 < 2;
      if (i0 < 2) d0 = a[i0];
      if (i1 < 2) d1 = b[i1];
    end
    wait_idle("contention", 100);
    w[0] = a[0]; w[1] = b[0]; w[2] = a[1]; w[3] = b[1];
    chk("contention count", 32'(sent.size()), 32'd4);
    for (int i = 0; i < 4 && i < sent.size(); i++) chk("contention order", sent[i], w[i]);
    // full FIFO with the transmitter stalled
    do_reset();
    hold_low = 1;
    k = 0;
    v0 = 1'b1;
    d0 = 32'h100;
    repeat (20) begin
      step();
      if (acc0) k++;
      d0 = 32'h100 + 32'(k);
    end
    chk("full fifo_count", 32'(fifo_count_o), 32'(DEPTH));
    chk("full req0_ready", 32'(r0), 32'h0);
    chk("full accepted incl in-flight", 32'(k), 32'(DEPTH + 1));
    hold_low = 0;
    for (int i = 0; i < 200 && k < DEPTH + 3; i++) begin
      step();
      if (acc0) k++;
      d0 = 32'h100 + 32'(k);
    end
    v0 = 1'b0;
    chk("full drained accepts", 32'(k), 32'(DEPTH + 3));
    wait_idle("full drain", 200);
    // stuck-high done
    do_reset();
    sent.delete();
    stuck = 1;
    v0 = 1'b1; d0 = 32'h5A5A_0001;
    step();
    v0 = 1'b0;
    v1 = 1'b1; d1 = 32'h5A5A_0002;
    step();
    v1 = 1'b0;
    repeat (30) step();
    chk("stuck idle", 32'(idle_o), 32'h1);
    chk("stuck transfers", 32'(sent.size()), 32'd2);
    stuck = 0;
    step();
    // reset while waiting with two words queued
    do_reset();
    sent.delete();
    hold_low = 1;
    v0 = 1'b1;
    d0 = 32'hC0DE_0000;
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      step();
      if (acc0) k++;
      d0 = 32'hC0DE_0000 + 32'(k);
    end
    v0 = 1'b0;
    step();
    chk("midreset queued", 32'(fifo_count_o), 32'd2);
    do_reset();
    hold_low = 0;
    repeat (20) step();
    chk("midreset fifo_count", 32'(fifo_count_o), 32'h0);
    chk("midreset idle", 32'(idle_o), 32'h1);
    chk("midreset transfers", 32'(sent.size()), 32'd1);
    // wrap: ten single-word transfers through the pointers
    do_reset();
    sent.delete();
    for (int n = 0; n < 10; n++) begin
      if (n % 2 == 0) begin v0 = 1'b1; d0 = $urandom; end
      else begin v1 = 1'b1; d1 = $urandom; end
      for (int i = 0; i < 10; i++) begin
        step();
        if (acc0 || acc1) break;
      end
      v0 = 1'b0;
      v1 = 1'b0;
      wait_idle("wrap", 100);
    end
    chk("wrap transfers", 32'(sent.size()), 32'd10);
    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step();
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = $urandom;
      d1 = $urandom;
      hold_low = $urandom_range(0, 7) == 0;
    end
    v0 = 1'b0;
    v1 = 1'b0;
    hold_low = 0;
    wait_idle("random drain", 400);
    chk("random queue empty", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
